// File: rtl/gf_nb_frob.sv
`default_nettype none
// ============================================================================
//  Module      : gf_nb_frob
//  Description : Normal-basis GF(2^m) Frobenius engine. Computes A^(2^k)
//                (cyclic rotate left per step) or A^(2^-k) (cyclic rotate
//                right per step), one step per clock, valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_nb_frob #(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [KW-1:0]    in_k,
  input  logic             in_root,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [KW-1:0]    cnt_q,   cnt_d;
  logic             mode_q,  mode_d;

  // In normal basis squaring is a pure rotation, so no field arithmetic is
  // needed; k >= WIDTH wraps naturally because WIDTH rotations are identity.
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_rt;
  assign w_sq = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
  assign w_rt = {work_q[0], work_q[WIDTH-1:1]};

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath update; inputs are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_a;
          cnt_d   = in_k;
          mode_d  = in_root;
          state_d = (in_k == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        work_d = mode_q ? w_rt : w_sq;
        cnt_d  = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_q     = work_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gf_nb_frob.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_nb_frob
//  Description : Scoreboard bench for gf_nb_frob (WIDTH=8 and WIDTH=2 units).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_nb_frob;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // WIDTH=8 instance signals
  logic       in_valid = 1'b0, in_ready, in_root = 1'b0;
  logic [7:0] in_a = '0, out_q;
  logic [3:0] in_k = '0;
  logic       out_valid, out_ready = 1'b1;

  // WIDTH=2 instance signals
  logic       in2_valid = 1'b0, in2_ready, in2_root = 1'b0;
  logic [1:0] in2_a = '0, out2_q;
  logic [3:0] in2_k = '0;
  logic       out2_valid, out2_ready = 1'b1;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] q8[$];
  logic [1:0] q2[$];

  gf_nb_frob #(.WIDTH(8), .KW(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_k(in_k),
    .in_root(in_root), .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q)
  );

  gf_nb_frob #(.WIDTH(2), .KW(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_a(in2_a), .in_k(in2_k),
    .in_root(in2_root), .out_valid(out2_valid), .out_ready(out2_ready), .out_q(out2_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q8.size() == 0) chk("w8 unexpected output", 64'(out_q), 64'hDEAD);
      else chk("w8 result", 64'(out_q), 64'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && out2_valid && out2_ready) begin
      if (q2.size() == 0) chk("w2 unexpected output", 64'(out2_q), 64'hDEAD);
      else chk("w2 result", 64'(out2_q), 64'(q2.pop_front()));
    end
  end

  task automatic wait_idle8();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) chk("w8 in_ready timeout", 64'(in_ready), 64'd1);
  endtask

  // Issue one request; optionally measure latency and wait for completion.
  task automatic issue8(input logic [7:0] a, input logic [3:0] k, input logic root,
                        input logic [7:0] exp, input bit push, input bit wait_done);
    int lat;
    wait_idle8();
    in_a = a; in_k = k; in_root = root; in_valid = 1'b1;
    @(posedge clk);
    if (push) q8.push_back(exp);
    #1;
    in_valid = 1'b0;
    in_a = ~a; in_k = ~k; in_root = ~root;
    if (wait_done) begin
      lat = 0;
      forever begin
        @(negedge clk);
        if (out_valid || lat > 100) break;
        lat++;
      end
      chk("w8 latency", 64'(lat), 64'(k));
      @(posedge clk); #1;
      wait_idle8();
    end
  endtask

  task automatic issue2(input logic [1:0] a, input logic [3:0] k, input logic root,
                        input logic [1:0] exp);
    int t = 0;
    while (!in2_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    in2_a = a; in2_k = k; in2_root = root; in2_valid = 1'b1;
    @(posedge clk);
    q2.push_back(exp);
    #1;
    in2_valid = 1'b0;
    in2_a = ~a; in2_k = 4'hF; in2_root = ~root;
    t = 0;
    while (!out2_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("w2 out_valid seen", 64'(out2_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held;
    int t;
    // Reset state
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_q", 64'(out_q), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Directed vectors
    issue8(8'h81, 4'd1, 1'b0, 8'h03, 1'b1, 1'b1);
    issue8(8'h81, 4'd1, 1'b1, 8'hC0, 1'b1, 1'b1);
    issue8(8'h5A, 4'd8, 1'b0, 8'h5A, 1'b1, 1'b1);
    issue8(8'h5A, 4'd8, 1'b1, 8'h5A, 1'b1, 1'b1);
    issue8(8'h5A, 4'd0, 1'b0, 8'h5A, 1'b1, 1'b1);
    issue8(8'h01, 4'd3, 1'b0, 8'h08, 1'b1, 1'b1);
    issue8(8'h08, 4'd5, 1'b0, 8'h01, 1'b1, 1'b1);
    issue8(8'h08, 4'd3, 1'b1, 8'h01, 1'b1, 1'b1);
    issue8(8'h01, 4'd15, 1'b0, 8'h80, 1'b1, 1'b1);
    issue8(8'h01, 4'd15, 1'b1, 8'h02, 1'b1, 1'b1);

    // Backpressure: hold out_ready low for 10 cycles in DONE
    out_ready = 1'b0;
    issue8(8'h3C, 4'd2, 1'b0, 8'hF0, 1'b1, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    held = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp out_q", 64'(out_q), 64'(held));
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp in_ready after release", 64'(in_ready), 64'd1);
    chk("bp out_valid after release", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-RUN discards the operation
    issue8(8'h81, 4'd6, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #3;
    chk("run in_ready low", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1; rst = 1'b0;
    issue8(8'h81, 4'd2, 1'b0, 8'h06, 1'b1, 1'b1);

    // Input toggling during RUN must not affect the result
    issue8(8'h01, 4'd5, 1'b1, 8'h08, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_k = 4'($urandom); in_root = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle8();

    // WIDTH=2 instance
    issue2(2'b10, 4'd1, 1'b0, 2'b01);
    issue2(2'b10, 4'd1, 1'b1, 2'b01);
    issue2(2'b01, 4'd2, 1'b0, 2'b01);
    issue2(2'b01, 4'd3, 1'b1, 2'b10);

    repeat (3) @(posedge clk);
    chk("w8 scoreboard drained", 64'(q8.size()), 64'd0);
    chk("w2 scoreboard drained", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
